fdivsu_seq: RTL and testbench

FDIVSU_SEQ -- requirements
Module: fdivsu_seq

---
 rtl/fdivsu_seq_if.sv | 39 +++
 rtl/fdivsu_seq.sv | 161 ++++++++++++++++
 tb/tb_fdivsu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fdivsu_seq_if.sv
// rtl/fdivsu_seq_if.sv - request/result bundle for the fdivsu_seq divider
//
// Purpose: groups the start/operand request and the registered result of
// fdivsu_seq so the divider and its user connect through one port.
//
// Signals:
//   i_start  request pulse/level, sampled by the divider only when idle
//   i_r1     signed dividend high byte (fractional-multiply result format)
//   i_r0     dividend low byte, bit 0 ignored
//   i_rr     unsigned divisor
//   o_q      signed, saturated quotient
//   o_rem    unsigned remainder magnitude
//   o_ovf    overflow / divide-by-zero flag
//   o_busy   division in progress
//   o_done   one-cycle pulse when o_q/o_rem/o_ovf update
//
// Modports: master drives the request and observes the result,
//           slave (the divider) does the opposite.
interface fdivsu_seq_if;
  logic       i_start;
  logic [7:0] i_r1;
  logic [7:0] i_r0;
  logic [7:0] i_rr;
  logic [7:0] o_q;
  logic [7:0] o_rem;
  logic       o_ovf;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_start, i_r1, i_r0, i_rr,
    input  o_q, o_rem, o_ovf, o_busy, o_done
  );

  modport slave (
    input  i_start, i_r1, i_r0, i_rr,
    output o_q, o_rem, o_ovf, o_busy, o_done
  );
endinterface

// File: rtl/fdivsu_seq.sv
// rtl/fdivsu_seq.sv - sequential signed-by-unsigned fractional divider
//
// Purpose: divides the 15-bit signed raw product P = {i_r1,i_r0}[15:1]
// (sign-extended) by the unsigned byte i_rr with a 16-step restoring
// shift-subtract loop. Quotient is truncated toward zero and saturated to
// a signed byte; remainder is |P| mod i_rr. Fixed 17-edge latency.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      fdivsu_seq_if.slave: i_start, i_r1, i_r0, i_rr in;
//            o_q, o_rem, o_ovf, o_busy, o_done out
module fdivsu_seq (
  input logic         i_clk,
  input logic         i_rst_n,
  fdivsu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in
  // at the bottom; after 16 steps it holds the quotient magnitude.
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  part_q, part_d;   // partial remainder
  logic [7:0]  div_q, div_d;     // latched divisor
  logic        neg_q, neg_d;     // sign of P
  logic [7:0]  q_q, q_d;
  logic [7:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  // Operand decode: bit 0 of the low byte is masked, then an arithmetic
  // shift recovers the raw signed product P.
  logic [15:0] p_in;
  logic [15:0] p_ext;
  logic [15:0] p_mag;

  assign p_in  = {bus.i_r1, bus.i_r0 & 8'hFE};
  assign p_ext = 16'($signed(p_in) >>> 1);
  assign p_mag = p_ext[15] ? (~p_ext + 16'd1) : p_ext;

  // One restoring step: the 9-bit trial value cannot exceed 2*div-1, and
  // when it is >= div the difference fits in 8 bits.
  logic [8:0] trial;
  logic       take;
  logic [7:0] trial_sub;

  assign trial     = {part_q, dvd_q[15]};
  assign take      = (trial >= {1'b0, div_q});
  assign trial_sub = trial[7:0] - div_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    part_d  = part_q;
    div_d   = div_q;
    neg_d   = neg_q;
    q_d     = q_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          dvd_d   = p_mag;
          neg_d   = p_ext[15];
          div_d   = bus.i_rr;
          part_d  = 8'd0;
          cnt_d   = 5'd0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        dvd_d  = {dvd_q[14:0], take};
        part_d = take ? trial_sub : trial[7:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (div_q == 8'd0) begin
          // Divide-by-zero saturates toward the sign of P (P=0 counts as +).
          q_d   = neg_q ? 8'h80 : 8'h7F;
          rem_d = 8'd0;
          ovf_d = 1'b1;
        end else if (!neg_q) begin
          if (dvd_q > 16'd127) begin
            q_d   = 8'h7F;
            rem_d = 8'd0;
            ovf_d = 1'b1;
          end else begin
            q_d   = dvd_q[7:0];
            rem_d = part_q;
            ovf_d = 1'b0;
          end
        end else begin
          // Negative side reaches one further: magnitude 128 is exactly -128.
          if (dvd_q > 16'd128) begin
            q_d   = 8'h80;
            rem_d = 8'd0;
            ovf_d = 1'b1;
          end else begin
            q_d   = ~dvd_q[7:0] + 8'd1;
            rem_d = part_q;
            ovf_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 16'd0;
      part_q  <= 8'd0;
      div_q   <= 8'd0;
      neg_q   <= 1'b0;
      q_q     <= 8'd0;
      rem_q   <= 8'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      part_q  <= part_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_q    = q_q;
  assign bus.o_rem  = rem_q;
  assign bus.o_ovf  = ovf_q;
  assign bus.o_done = done_q;
  assign bus.o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fdivsu_seq.sv
// tb/tb_fdivsu_seq.sv - scoreboard testbench for fdivsu_seq
module tb_fdivsu_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [7:0] q;
    logic [7:0] rem;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  logic [7:0] last_q;
  logic [7:0] last_rem;
  logic       last_ovf;

  fdivsu_seq_if bus ();

  fdivsu_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one division at the current falling edge. The result is expected
  // 18 rising edges later in cycle count (E0..E17). With hold=1 i_start stays
  // high, so the next call lands exactly on E18. Operands are scrambled
  // while the division runs.
  task automatic do_op(input logic [7:0] r1, input logic [7:0] r0, input logic [7:0] rr,
                       input logic [7:0] eq, input logic [7:0] erem, input logic eovf,
                       input logic hold);
    exp_t e;
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    bus.i_start = 1'b1;
    bus.i_r1    = r1;
    bus.i_r0    = r0;
    bus.i_rr    = rr;
    e.q   = eq;
    e.rem = erem;
    e.ovf = eovf;
    e.cyc = cyc + 18;
    sb.push_back(e);
    @(negedge clk);
    chk("busy", 32'(bus.o_busy), 32'd1);
    bus.i_start = hold;
    bus.i_r1    = 8'($urandom);
    bus.i_r0    = 8'($urandom);
    bus.i_rr    = 8'($urandom);
    repeat (17) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every o_done, otherwise checks that the
  // result registers hold (or are cleared while in reset).
  initial begin
    exp_t e;
    last_q   = 8'd0;
    last_rem = 8'd0;
    last_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_q   = 8'd0;
        last_rem = 8'd0;
        last_ovf = 1'b0;
        chk("reset_outputs",
            32'({bus.o_q, bus.o_rem, bus.o_ovf, bus.o_busy, bus.o_done}), 32'd0);
      end else if (bus.o_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_done=1 at cycle %0d, expected no result pending", cyc);
        end else begin
          e = sb.pop_front();
          chk("o_q", 32'(bus.o_q), 32'(e.q));
          chk("o_rem", 32'(bus.o_rem), 32'(e.rem));
          chk("o_ovf", 32'(bus.o_ovf), 32'(e.ovf));
          chk("latency", 32'(cyc), 32'(e.cyc));
          last_q   = e.q;
          last_rem = e.rem;
          last_ovf = e.ovf;
        end
      end else begin
        chk("hold", 32'({bus.o_q, bus.o_rem, bus.o_ovf}), 32'({last_q, last_rem, last_ovf}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time %0t, expected bench to finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_r1    = 8'd0;
    bus.i_r0    = 8'd0;
    bus.i_rr    = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(bus.o_q), 32'd0);
    chk("rst_rem", 32'(bus.o_rem), 32'd0);
    chk("rst_ovf", 32'(bus.o_ovf), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    //     r1     r0     rr       q      rem    ovf   hold
    do_op(8'h9C, 8'h00, 8'd200, 8'hC0, 8'h00, 1'b0, 1'b0); // -12800/200
    do_op(8'h02, 8'h58, 8'd3,   8'h64, 8'h00, 1'b0, 1'b0); // 300/3
    do_op(8'hFF, 8'hF2, 8'd2,   8'hFD, 8'h01, 1'b0, 1'b0); // -7/2
    do_op(8'h7F, 8'hFE, 8'd1,   8'h7F, 8'h00, 1'b1, 1'b0); // 16383/1 sat
    do_op(8'h80, 8'h00, 8'd128, 8'h80, 8'h00, 1'b0, 1'b0); // -16384/128
    do_op(8'h02, 8'h58, 8'd0,   8'h7F, 8'h00, 1'b1, 1'b0); // 300/0
    do_op(8'h00, 8'h00, 8'd0,   8'h7F, 8'h00, 1'b1, 1'b0); // 0/0
    do_op(8'hFF, 8'hF2, 8'd0,   8'h80, 8'h00, 1'b1, 1'b0); // -7/0
    do_op(8'h01, 8'h00, 8'd1,   8'h7F, 8'h00, 1'b1, 1'b0); // 128/1 sat
    do_op(8'hFE, 8'hFE, 8'd1,   8'h80, 8'h00, 1'b1, 1'b0); // -129/1 sat
    do_op(8'hFF, 8'h00, 8'd1,   8'h80, 8'h00, 1'b0, 1'b0); // -128/1 exact
    do_op(8'h07, 8'hD0, 8'd9,   8'h6F, 8'h01, 1'b0, 1'b0); // 1000/9
    do_op(8'hF8, 8'h30, 8'd9,   8'h91, 8'h01, 1'b0, 1'b0); // -1000/9
    do_op(8'h07, 8'hD0, 8'd7,   8'h7F, 8'h00, 1'b1, 1'b0); // 1000/7 sat
    do_op(8'h02, 8'h59, 8'd3,   8'h64, 8'h00, 1'b0, 1'b0); // bit 0 ignored
    do_op(8'h7F, 8'h58, 8'd163, 8'h64, 8'h00, 1'b0, 1'b0); // round trip 100*163
    do_op(8'h7F, 8'hFE, 8'd255, 8'h40, 8'h3F, 1'b0, 1'b0); // 16383/255

    // Back-to-back with i_start held high.
    do_op(8'h02, 8'h58, 8'd3,   8'h64, 8'h00, 1'b0, 1'b1);
    do_op(8'hFF, 8'hF2, 8'd2,   8'hFD, 8'h01, 1'b0, 1'b1);
    do_op(8'hF8, 8'h30, 8'd9,   8'h91, 8'h01, 1'b0, 1'b0);

    // Reset five cycles into a division: no result, outputs cleared at once.
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    bus.i_start = 1'b1;
    bus.i_r1    = 8'h07;
    bus.i_r0    = 8'hD0;
    bus.i_rr    = 8'd9;
    @(negedge clk);
    chk("busy", 32'(bus.o_busy), 32'd1);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_q", 32'(bus.o_q), 32'd0);
    chk("abort_rem_ovf", 32'({bus.o_rem, bus.o_ovf}), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_op(8'h9C, 8'h00, 8'd200, 8'hC0, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
